cla_accumulator: RTL
====================

Name: cla_accumulator

Overview:
Sequential consumer/driver of the existing 32-bit CLA adder (ports A, B, Cin, S, Cout). Accepts a burst of `len` 32-bit operands over a valid/ready stream and sums them into a running accumulator through one CLA instance. It counts carry-outs beyond bit 31 and then presents the total on a valid/ready result port. It is the operand-sequencing and result-capture stage wrapped around the adder.

Parameters:
CNT_W, 8, width of the burst length, the remaining-beats counter and the carry-out counter.
(Data width is fixed at 32 to match CLA; not parameterised.)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a burst; sampled only in IDLE
len  input  CNT_W  operand count for the burst, sampled with start
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts an operand this cycle
in_data  input  32  operand
in_cin  input  1  carry-in applied to this beat's addition
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  32  accumulated sum modulo 2^32
out_carries  output  CNT_W  number of beats whose Cout was 1, wraps modulo 2^CNT_W
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset, applied on any edge with rst=1 and taking priority over everything:
  - state=IDLE; acc, carries and remaining are cleared.
  - in_ready=0, out_valid=0, busy=0, out_sum=0, out_carries=0.
- FSM states are IDLE, ACCUM and DONE.
- IDLE:
  - On start=1 with len!=0: acc<=0, carries<=0, remaining<=len, go to ACCUM.
  - On start=1 with len==0: acc<=0, carries<=0, go directly to DONE.
- ACCUM:
  - in_ready=1 combinationally from state.
  - A beat is accepted when in_valid && in_ready.
  - CLA inputs: A=acc, B=in_data, Cin=in_cin. They are driven combinationally; the CLA output is registered only on acceptance.
  - On acceptance: acc<=S; carries<=carries+Cout (wrapping); remaining<=remaining-1.
  - When remaining==1 at acceptance, go to DONE.
  - A cycle with no accepted beat holds all state.
- DONE:
  - out_valid=1; out_sum and out_carries are held stable.
  - On out_ready=1, go to IDLE. out_valid stays high until the handshake completes.
- Latency:
  - start accepted at cycle T → in_ready high at T+1.
  - Last beat accepted at Tk → out_valid high at Tk+1.
  - len==0 → out_valid high at T+1.
  - Back-to-back bursts: start may be accepted in the cycle after the out handshake, i.e. the first IDLE cycle.
- Outputs in IDLE: out_sum and out_carries keep the last result until the next start. They are meaningful only with out_valid=1.
- Signals ignored when not in their state:
  - start and len are ignored outside IDLE.
  - in_valid is ignored outside ACCUM; in_ready=0 there.
  - out_ready is ignored outside DONE.
- Reset mid-burst: the partial sum is discarded and no out_valid is produced.
- Wrap-around: the sum is modulo 2^32. Overflow is visible only via out_carries. out_carries wraps silently past 2^CNT_W-1.

Decomposition:
- Shared package: FSM state enum (IDLE, ACCUM, DONE) and the CNT_W default constant.
- One sub-module: the existing CLA, instantiated once.
- All other logic (FSM, acc/remaining/carries registers) is local.

Test Plan:
- Small sum: start len=2; beats 0x00000003 cin0 and 0x00000005 cin0 → out_sum=0x00000008, out_carries=0, out_valid one cycle after beat 2.
- Carry-out: len=2; beats 0xFFFFFFFF cin0 and 0x00000001 cin0 → out_sum=0x00000000, out_carries=1.
- Carry-in: len=2; beats 0x0000ABCD cin0 and 0x00001234 cin1 → out_sum=0x0000BE02, out_carries=0.
- Empty burst and backpressure:
  - len=0 → out_valid at T+1 with out_sum=0, out_carries=0.
  - Hold out_ready=0 for 5 cycles → out_valid and data stable; IDLE only after out_ready=1.
  - start pulses during DONE are ignored.
- Stalls and wrap: len=4 with in_valid gaps between beats, all beats 0x80000000 → out_sum=0x00000000, out_carries=2. Verify the accepted-beat count by counting in_valid&&in_ready.
- Reset mid-burst: len=3, accept 1 beat, assert rst one cycle → state IDLE, in_ready=0, out_valid never rises. A following burst len=1 with beat 0x7 → out_sum=0x00000007.

Source files
------------

// File: rtl/cla_accumulator_pkg.sv
// cla_accumulator_pkg
//   Shared definitions for the CLA burst accumulator: the controller state
//   encoding, the fixed datapath width and the default counter width.
package cla_accumulator_pkg;

  // Data width is tied to the 32-bit CLA and is fixed.
  localparam int DATA_W    = 32;

  // Default width of the burst length, remaining-beat and carry-out counters.
  localparam int CNT_W_DEF = 8;

  // Lookahead grouping used inside the adder: 8 groups of 4 bits.
  localparam int GRP_W     = 4;
  localparam int GRP_N     = DATA_W / GRP_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/cla_accumulator_cla.sv
// cla_accumulator_cla
//   The existing 32-bit carry-lookahead adder, S = A + B + Cin.
//   Two-level lookahead: each 4-bit group resolves its internal carries in
//   parallel from the group carry-in, and group generate/propagate terms
//   produce the group carries.
// Ports
//   A, B  : 32-bit addends
//   Cin   : carry into bit 0
//   S     : 32-bit sum
//   Cout  : carry out of bit 31
module cla_accumulator_cla
  import cla_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Cin,
  output logic [DATA_W-1:0] S,
  output logic              Cout
);

  logic [DATA_W-1:0] gen;
  logic [DATA_W-1:0] prop;
  logic [DATA_W-1:0] carry;
  logic [GRP_N:0]    grp_c;

  assign gen  = A & B;
  assign prop = A ^ B;

  always_comb begin
    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    logic             c0;
    logic             grp_g;
    logic             grp_p;
    carry    = '0;
    grp_c    = '0;
    g        = '0;
    p        = '0;
    c0       = 1'b0;
    grp_g    = 1'b0;
    grp_p    = 1'b0;
    grp_c[0] = Cin;
    for (int b = 0; b < GRP_N; b++) begin
      g  = gen[b*GRP_W +: GRP_W];
      p  = prop[b*GRP_W +: GRP_W];
      c0 = grp_c[b];
      // Internal carries of the group, fully expanded from the group carry-in.
      carry[b*GRP_W + 0] = c0;
      carry[b*GRP_W + 1] = g[0] | (p[0] & c0);
      carry[b*GRP_W + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      carry[b*GRP_W + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                         | (p[2] & p[1] & p[0] & c0);
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p;
      grp_c[b+1] = grp_g | (grp_p & c0);
    end
  end

  assign S    = prop ^ carry;
  assign Cout = grp_c[GRP_N];

endmodule

// File: rtl/cla_accumulator.sv
// cla_accumulator
//   Burst accumulator wrapped around a single 32-bit CLA. A start pulse in
//   IDLE loads the beat count; each accepted operand beat is added into the
//   running sum together with its own carry-in, and every carry out of bit 31
//   is counted. When the last beat lands, the total is offered on the result
//   port until the consumer takes it.
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   start, len   : begin a burst of len beats (sampled only in IDLE)
//   in_valid/in_ready, in_data, in_cin : operand stream
//   out_valid/out_ready, out_sum, out_carries : result port
//   busy         : high while a burst is in progress or its result is pending
module cla_accumulator
  import cla_accumulator_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_carries,
  output logic              busy
);

  // Carry-out counter increments silently wrap at 2^CNT_W.
  function automatic logic [CNT_W-1:0] add_carry(input logic [CNT_W-1:0] cnt,
                                                 input logic             co);
    return cnt + CNT_W'(co);
  endfunction

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  carries;
  logic [CNT_W-1:0]  remaining;

  logic [DATA_W-1:0] cla_s;
  logic              cla_cout;
  logic              accept;

  // The adder always sees the current sum and the offered beat; its result
  // is only committed when the beat is actually accepted.
  cla_accumulator_cla u_cla (
    .A    (acc),
    .B    (in_data),
    .Cin  (in_cin),
    .S    (cla_s),
    .Cout (cla_cout)
  );

  assign in_ready    = (state == ACCUM);
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign out_sum     = acc;
  assign out_carries = carries;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      carries   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            carries <= '0;
            if (len == '0) begin
              // Empty burst: result (zero) is ready on the next cycle.
              state <= DONE;
            end else begin
              remaining <= len;
              state     <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc       <= cla_s;
            carries   <= add_carry(carries, cla_cout);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
